// File: rtl/scratch_sched_pkg.sv
// Shared types and default geometry for the scratchpad write scheduler.
package scratch_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_DEPTH   = 16;

    // Address geometry for the default configuration; the scheduler re-derives
    // these from its own parameters so non-default builds stay consistent.
    localparam int ID_W   = $clog2(DEF_NUM_REQ);
    localparam int PTR_W  = $clog2(DEF_DEPTH);
    localparam int ADDR_W = ID_W + PTR_W;

endpackage

// File: rtl/scratch_write_scheduler_rr_arbiter.sv
// Stateless round-robin picker: first eligible index at or after prio, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [ID_W-1:0]    prio,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    // NUM_REQ is a power of two, so the ID_W-bit sum wraps modulo NUM_REQ for free.
    always_comb begin
        logic found;
        logic [ID_W-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = prio + ID_W'(i);
            if (!found && eligible[idx]) begin
                found       = 1'b1;
                grant_idx   = idx;
                grant[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scratch_write_scheduler.sv
// Round-robin sharing of the scratchpad write port across NUM_REQ fill regions.
// Optional macro SCRATCH_WR_BURST_LOCK_EN: granted requester keeps the port while it has data.
module scratch_write_scheduler
    import scratch_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic [NUM_REQ*DATA_W-1:0]           wdata,
    output logic [NUM_REQ-1:0]                  gnt,
    output logic                                scratch_we,
    output logic [$clog2(NUM_REQ*DEPTH)-1:0]    scratch_addr,
    output logic [DATA_W-1:0]                   scratch_wdata,
    output logic [NUM_REQ-1:0]                  full,
    output logic                                busy,
    output logic                                done
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int PW = $clog2(DEPTH);
    localparam int AW = IW + PW;

    state_t            state_q, state_d;
    logic [IW-1:0]     prio_q, prio_d;
    logic [PW-1:0]     ptr_q [NUM_REQ];
    logic [PW-1:0]     ptr_d [NUM_REQ];
    logic [NUM_REQ-1:0] full_q, full_d;
    logic              we_q, we_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      grant_idx;
    logic               last_word;

    assign eligible = (state_q == RUN) ? (req & ~full_q) : '0;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (IW)
    ) u_arb (
        .eligible  (eligible),
        .prio      (prio_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign last_word = (ptr_q[grant_idx] == PW'(DEPTH - 1));

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        ptr_d   = ptr_q;
        full_d  = full_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    full_d  = '0;
                    for (int i = 0; i < NUM_REQ; i++) ptr_d[i] = '0;
                end
            end
            RUN: begin
                if (|grant) begin
                    we_d    = 1'b1;
                    addr_d  = {grant_idx, ptr_q[grant_idx]};
                    wdata_d = wdata[int'(grant_idx)*DATA_W +: DATA_W];
                    ptr_d[grant_idx] = ptr_q[grant_idx] + 1'b1;
                    if (last_word) full_d[grant_idx] = 1'b1;
`ifdef SCRATCH_WR_BURST_LOCK_EN
                    // Parking prio on the holder keeps it first in line until it fills or drops req.
                    prio_d = last_word ? IW'(grant_idx + 1'b1) : grant_idx;
`else
                    prio_d = IW'(grant_idx + 1'b1);
`endif
                end
                if (&full_d) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= '0;
            ptr_q   <= '{default: '0};
            full_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            ptr_q   <= ptr_d;
            full_q  <= full_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign gnt           = grant;
    assign scratch_we    = we_q;
    assign scratch_addr  = addr_q;
    assign scratch_wdata = wdata_q;
    assign full          = full_q;
    assign busy          = (state_q == RUN);
    assign done          = (state_q == DONE);

endmodule

// File: tb/tb_scratch_write_scheduler.sv
// Directed bench for scratch_write_scheduler (NUM_REQ=4, DATA_W=16, DEPTH=16).
module tb_scratch_write_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  req;
    logic [63:0] wdata;
    logic [3:0]  gnt;
    logic        scratch_we;
    logic [5:0]  scratch_addr;
    logic [15:0] scratch_wdata;
    logic [3:0]  full;
    logic        busy;
    logic        done;

    int n_cmp  = 0;
    int n_fail = 0;

    scratch_write_scheduler #(
        .NUM_REQ (4),
        .DATA_W  (16),
        .DEPTH   (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .req           (req),
        .wdata         (wdata),
        .gnt           (gnt),
        .scratch_we    (scratch_we),
        .scratch_addr  (scratch_addr),
        .scratch_wdata (scratch_wdata),
        .full          (full),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        req   = 4'b0000;
        wdata = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_gnt got %b want 0000", gnt); end
        n_cmp++; if (scratch_we !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_we got %b want 0", scratch_we); end
        n_cmp++; if (scratch_addr !== 6'd0) begin n_fail++; $display("[TB] FAIL reset_addr got %h want 00", scratch_addr); end
        n_cmp++; if (scratch_wdata !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_wdata got %h want 0000", scratch_wdata); end
        n_cmp++; if (full !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_full got %b want 0000", full); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done got %b want 0", done); end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001;
        do_start();
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL single_busy got %b want 1", busy); end
        for (int k = 0; k < 16; k++) begin
            wdata[15:0] = 16'h1000 + 16'(k);
            #1;
            n_cmp++; if (gnt !== 4'b0001) begin n_fail++; $display("[TB] FAIL single_gnt k=%0d got %b want 0001", k, gnt); end
            tick();
            n_cmp++; if (scratch_we !== 1'b1) begin n_fail++; $display("[TB] FAIL single_we k=%0d got %b want 1", k, scratch_we); end
            n_cmp++; if (scratch_addr !== 6'(k)) begin n_fail++; $display("[TB] FAIL single_addr k=%0d got %h want %h", k, scratch_addr, 6'(k)); end
            n_cmp++; if (scratch_wdata !== 16'h1000 + 16'(k)) begin n_fail++; $display("[TB] FAIL single_wdata k=%0d got %h want %h", k, scratch_wdata, 16'h1000 + 16'(k)); end
        end
        n_cmp++; if (full !== 4'b0001) begin n_fail++; $display("[TB] FAIL single_full got %b want 0001", full); end
        n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("[TB] FAIL single_gnt_after_full got %b want 0000", gnt); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL single_done got %b want 0", done); end
        tick();
        n_cmp++; if (scratch_we !== 1'b0) begin n_fail++; $display("[TB] FAIL single_we_idle got %b want 0", scratch_we); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL single_busy_end got %b want 1", busy); end
    endtask

    task automatic test_all_four();
        int er;
        do_reset();
        req = 4'b1111;
        do_start();
        for (int n = 0; n < 64; n++) begin
            for (int r = 0; r < 4; r++) wdata[r*16 +: 16] = {4'h2, 4'(r), 8'(n)};
            er = n % 4;
            #1;
            n_cmp++; if (gnt !== 4'(1 << er)) begin n_fail++; $display("[TB] FAIL all_gnt n=%0d got %b want %b", n, gnt, 4'(1 << er)); end
            tick();
            n_cmp++; if (scratch_we !== 1'b1) begin n_fail++; $display("[TB] FAIL all_we n=%0d got %b want 1", n, scratch_we); end
            n_cmp++; if (scratch_addr !== 6'(er*16 + n/4)) begin n_fail++; $display("[TB] FAIL all_addr n=%0d got %h want %h", n, scratch_addr, 6'(er*16 + n/4)); end
            n_cmp++; if (scratch_wdata !== {4'h2, 4'(er), 8'(n)}) begin n_fail++; $display("[TB] FAIL all_wdata n=%0d got %h want %h", n, scratch_wdata, {4'h2, 4'(er), 8'(n)}); end
            if (n < 63) begin
                n_cmp++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL all_done_early n=%0d got %b want 0", n, done); end
            end
        end
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL all_done_pulse got %b want 1", done); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL all_busy_in_done got %b want 0", busy); end
        n_cmp++; if (full !== 4'b1111) begin n_fail++; $display("[TB] FAIL all_full got %b want 1111", full); end
        n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("[TB] FAIL all_gnt_in_done got %b want 0000", gnt); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL all_done_width got %b want 0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL all_busy_after got %b want 0", busy); end
        n_cmp++; if (scratch_we !== 1'b0) begin n_fail++; $display("[TB] FAIL all_we_after got %b want 0", scratch_we); end
    endtask

    task automatic test_full_skip();
        do_reset();
        req = 4'b0001;
        do_start();
        for (int k = 0; k < 16; k++) tick();
        n_cmp++; if (full !== 4'b0001) begin n_fail++; $display("[TB] FAIL skip_full0 got %b want 0001", full); end
        req = 4'b0011;
        for (int k = 0; k < 16; k++) begin
            wdata[31:16] = 16'h3000 + 16'(k);
            #1;
            n_cmp++; if (gnt !== 4'b0010) begin n_fail++; $display("[TB] FAIL skip_gnt k=%0d got %b want 0010", k, gnt); end
            tick();
            n_cmp++; if (scratch_addr !== 6'(16 + k)) begin n_fail++; $display("[TB] FAIL skip_addr k=%0d got %h want %h", k, scratch_addr, 6'(16 + k)); end
            n_cmp++; if (scratch_wdata !== 16'h3000 + 16'(k)) begin n_fail++; $display("[TB] FAIL skip_wdata k=%0d got %h want %h", k, scratch_wdata, 16'h3000 + 16'(k)); end
        end
        n_cmp++; if (full !== 4'b0011) begin n_fail++; $display("[TB] FAIL skip_full got %b want 0011", full); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL skip_done got %b want 0", done); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0001;
        do_start();
        for (int k = 0; k < 5; k++) tick();
        n_cmp++; if (scratch_addr !== 6'd4) begin n_fail++; $display("[TB] FAIL mid_addr_before got %h want 04", scratch_addr); end
        rst = 1'b1;
        #1;
        n_cmp++; if (scratch_we !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_we_async got %b want 0", scratch_we); end
        tick();
        n_cmp++; if (scratch_we !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_we got %b want 0", scratch_we); end
        n_cmp++; if (full !== 4'b0000) begin n_fail++; $display("[TB] FAIL mid_full got %b want 0000", full); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_done got %b want 0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_busy got %b want 0", busy); end
        rst = 1'b0;
        do_start();
        #1;
        n_cmp++; if (gnt !== 4'b0001) begin n_fail++; $display("[TB] FAIL mid_restart_gnt got %b want 0001", gnt); end
        tick();
        n_cmp++; if (scratch_addr !== 6'd0) begin n_fail++; $display("[TB] FAIL mid_restart_addr got %h want 00", scratch_addr); end
        n_cmp++; if (scratch_we !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_restart_we got %b want 1", scratch_we); end
    endtask

    task automatic test_start_in_run();
        do_reset();
        req = 4'b0001;
        do_start();
        for (int k = 0; k < 3; k++) tick();
        start = 1'b1;
        tick();
        n_cmp++; if (scratch_addr !== 6'd3) begin n_fail++; $display("[TB] FAIL run_start_addr3 got %h want 03", scratch_addr); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL run_start_busy got %b want 1", busy); end
        tick();
        start = 1'b0;
        n_cmp++; if (scratch_addr !== 6'd4) begin n_fail++; $display("[TB] FAIL run_start_addr4 got %h want 04", scratch_addr); end
        n_cmp++; if (scratch_we !== 1'b1) begin n_fail++; $display("[TB] FAIL run_start_we got %b want 1", scratch_we); end
    endtask

    task automatic test_back_to_back();
`ifdef SCRATCH_WR_BURST_LOCK_EN
        logic [3:0] want2 = 4'b0001;
        logic [5:0] want_addr3 = 6'h02;
`else
        logic [3:0] want2 = 4'b0010;
        logic [5:0] want_addr3 = 6'h01;
`endif
        do_reset();
        req = 4'b0011;
        do_start();
        #1;
        n_cmp++; if (gnt !== 4'b0001) begin n_fail++; $display("[TB] FAIL b2b_gnt1 got %b want 0001", gnt); end
        tick();
        n_cmp++; if (gnt !== want2) begin n_fail++; $display("[TB] FAIL b2b_gnt2 got %b want %b", gnt, want2); end
        tick();
        n_cmp++; if (gnt !== 4'b0001) begin n_fail++; $display("[TB] FAIL b2b_gnt3 got %b want 0001", gnt); end
        tick();
        n_cmp++; if (scratch_addr !== want_addr3) begin n_fail++; $display("[TB] FAIL b2b_addr3 got %h want %h", scratch_addr, want_addr3); end
        req = 4'b0010;
        #1;
        n_cmp++; if (gnt !== 4'b0010) begin n_fail++; $display("[TB] FAIL b2b_gnt4 got %b want 0010", gnt); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        req   = 4'b0000;
        wdata = '0;
        test_reset();
        test_single();
        test_all_four();
        test_full_skip();
        test_reset_mid();
        test_start_in_run();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
